// File: rtl/vfu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vfu_pkg
//  Description : Shared types and helpers for the vector execution unit:
//                opcode and FSM state encodings, beat-count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vfu_pkg;

    typedef enum logic [3:0] {
        VOP_ADD  = 4'd0,
        VOP_SUB  = 4'd1,
        VOP_MUL  = 4'd2,
        VOP_AND  = 4'd3,
        VOP_OR   = 4'd4,
        VOP_XOR  = 4'd5,
        VOP_SLL  = 4'd6,
        VOP_SRL  = 4'd7,
        VOP_SRA  = 4'd8,
        VOP_MIN  = 4'd9,
        VOP_MAX  = 4'd10,
        VOP_MINU = 4'd11,
        VOP_MAXU = 4'd12
    } vop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Encodings at or above this value are illegal opcodes
    localparam int unsigned NUM_OPS = 13;

    // Number of LANES-wide beats needed to cover vl elements
    function automatic int unsigned beat_count(input int unsigned vl, input int unsigned lanes);
        return (vl + lanes - 1) / lanes;
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        return (32'(op) < NUM_OPS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_lane_alu.sv
`default_nettype none
// ============================================================================
//  Module      : vector_lane_alu
//  Description : Single-element combinational ALU for one vector lane.
//                Illegal opcodes pass operand a through and flag illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_lane_alu #(
    parameter int ELEM_W = 32
) (
    input  logic [3:0]        op,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [ELEM_W-1:0] y,
    output logic              illegal
);
    import vfu_pkg::*;

    localparam int SH_W = $clog2(ELEM_W);

    logic [SH_W-1:0] w_sh;
    assign w_sh = b[SH_W-1:0];

    // Element operation select; default keeps a so illegal ops leave data untouched
    always_comb begin
        y       = a;
        illegal = 1'b0;
        case (op)
            VOP_ADD:  y = a + b;
            VOP_SUB:  y = a - b;
            VOP_MUL:  y = a * b;
            VOP_AND:  y = a & b;
            VOP_OR:   y = a | b;
            VOP_XOR:  y = a ^ b;
            VOP_SLL:  y = a << w_sh;
            VOP_SRL:  y = a >> w_sh;
            VOP_SRA:  y = ELEM_W'($signed(a) >>> w_sh);
            VOP_MIN:  y = ($signed(a) < $signed(b)) ? a : b;
            VOP_MAX:  y = ($signed(a) > $signed(b)) ? a : b;
            VOP_MINU: y = (a < b) ? a : b;
            VOP_MAXU: y = (a > b) ? a : b;
            default:  illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vector_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vector_exec_unit
//  Description : Strip-mined multi-lane vector execution unit. Accepts one
//                instruction, processes LANES elements per EXEC cycle and
//                returns the whole result vector over a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_exec_unit #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 32,
    parameter int MAX_VL = 16,
    parameter int VL_W   = $clog2(MAX_VL + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_op,
    input  logic [VL_W-1:0]          req_vl,
    input  logic [MAX_VL-1:0]        req_mask,
    input  logic [MAX_VL*ELEM_W-1:0] req_src_a,
    input  logic [MAX_VL*ELEM_W-1:0] req_src_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [MAX_VL*ELEM_W-1:0] resp_data,
    output logic                     resp_err,
    output logic                     busy
);
    import vfu_pkg::*;

    localparam int NBEATS  = MAX_VL / LANES;
    localparam int BEAT_W  = $clog2(NBEATS + 1);
    localparam int VEC_W   = MAX_VL * ELEM_W;
    localparam int BEAT_DW = LANES * ELEM_W;

    state_e              r_state;
    state_e              w_state_next;
    logic [3:0]          r_op;
    logic [VL_W-1:0]     r_vl;
    logic [MAX_VL-1:0]   r_mask;
    logic [VEC_W-1:0]    r_src_b;
    logic [VEC_W-1:0]    r_result;
    logic [BEAT_W-1:0]   r_beat;
    logic [BEAT_W-1:0]   r_last_beat;
    logic                r_resp_valid;
    logic                r_resp_err;

    logic                w_accept;
    logic                w_last;
    logic [VL_W-1:0]     w_vl_clamped;
    logic [31:0]         w_shift;
    logic [BEAT_DW-1:0]  w_a_beat;
    logic [BEAT_DW-1:0]  w_b_beat;
    logic [BEAT_DW-1:0]  w_y_beat;
    logic [LANES-1:0]    w_illegal;
    logic [MAX_VL-1:0]   w_we;
    logic [VEC_W-1:0]    w_result_next;

    assign w_vl_clamped = (req_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : req_vl;
    assign w_accept     = req_valid & req_ready;
    assign w_last       = (r_beat == r_last_beat);

    // The result register still holds src_a for every element not yet
    // written, so it doubles as operand A storage for the current beat.
    assign w_shift  = 32'(r_beat) * 32'(BEAT_DW);
    assign w_a_beat = BEAT_DW'(r_result >> w_shift);
    assign w_b_beat = BEAT_DW'(r_src_b >> w_shift);

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_data  = r_result;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state and decoded handshake/status outputs
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_next = (w_vl_clamped == '0) ? S_DONE : S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                busy = 1'b1;
                if (resp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Instruction capture, beat sequencing, result accumulation and response flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_vl         <= '0;
            r_mask       <= '0;
            r_src_b      <= '0;
            r_result     <= '0;
            r_beat       <= '0;
            r_last_beat  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else if (w_accept) begin
            r_op         <= req_op;
            r_vl         <= w_vl_clamped;
            r_mask       <= req_mask;
            r_src_b      <= req_src_b;
            r_result     <= req_src_a;
            r_beat       <= '0;
            r_last_beat  <= BEAT_W'(beat_count(32'(w_vl_clamped), LANES) - 1);
            r_resp_valid <= (w_vl_clamped == '0);
            r_resp_err   <= ~op_legal(req_op);
        end else if (r_state == S_EXEC) begin
            r_result <= w_result_next;
            r_beat   <= r_beat + BEAT_W'(1);
            if (w_last) r_resp_valid <= 1'b1;
        end else if ((r_state == S_DONE) && resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vector_lane_alu #(
            .ELEM_W (ELEM_W)
        ) u_alu (
            .op      (r_op),
            .a       (w_a_beat[l*ELEM_W +: ELEM_W]),
            .b       (w_b_beat[l*ELEM_W +: ELEM_W]),
            .y       (w_y_beat[l*ELEM_W +: ELEM_W]),
            .illegal (w_illegal[l])
        );
    end

    // Scatter lane results back; tail, masked and illegal-op elements keep src_a
    for (genvar e = 0; e < MAX_VL; e++) begin : g_elem
        assign w_we[e] = (r_beat == BEAT_W'(e / LANES)) && (VL_W'(e) < r_vl) &&
                         r_mask[e] && !w_illegal[e % LANES];
        assign w_result_next[e*ELEM_W +: ELEM_W] = w_we[e] ? w_y_beat[(e % LANES)*ELEM_W +: ELEM_W]
                                                           : r_result[e*ELEM_W +: ELEM_W];
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_exec_unit
//  Description : Directed, table-driven bench for vector_exec_unit plus
//                hand-written backpressure and mid-instruction reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_exec_unit;

    localparam int LANES  = 4;
    localparam int ELEM_W = 32;
    localparam int MAX_VL = 16;
    localparam int VL_W   = $clog2(MAX_VL + 1);
    localparam int VEC_W  = MAX_VL * ELEM_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_op = '0;
    logic [VL_W-1:0]   req_vl = '0;
    logic [MAX_VL-1:0] req_mask = '0;
    logic [VEC_W-1:0]  req_src_a = '0;
    logic [VEC_W-1:0]  req_src_b = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [VEC_W-1:0]  resp_data;
    logic              resp_err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_exec_unit #(
        .LANES  (LANES),
        .ELEM_W (ELEM_W),
        .MAX_VL (MAX_VL),
        .VL_W   (VL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_vl     (req_vl),
        .req_mask   (req_mask),
        .req_src_a  (req_src_a),
        .req_src_b  (req_src_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    typedef struct {
        logic [3:0]        op;
        logic [VL_W-1:0]   vl;
        logic [MAX_VL-1:0] mask;
        logic [VEC_W-1:0]  a;
        logic [VEC_W-1:0]  b;
        logic [VEC_W-1:0]  expd;
        logic              err;
        int                lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input int vl, input logic [MAX_VL-1:0] mask, input int lat);
        vec_t v;
        v.op = op; v.vl = VL_W'(vl); v.mask = mask; v.lat = lat; v.err = 1'b0;
        v.a = '0; v.b = '0; v.expd = '0;
        return v;
    endfunction

    // Every expected value below is worked out by hand from the opcode semantics
    task automatic build();
        vec_t v;
        // ADD vl=16: 100+i
        v = mk(4'd0, 16, 16'hFFFF, 4);
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'(i); v.b[i*32 +: 32] = 32'd100; v.expd[i*32 +: 32] = 32'(100 + i);
        end
        vecs.push_back(v);
        // SUB vl=6: 5-7 = -2 on 0..5, tail keeps 5
        v = mk(4'd1, 6, 16'h003F, 2);
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'd5; v.b[i*32 +: 32] = 32'd7;
            v.expd[i*32 +: 32] = (i < 6) ? 32'hFFFF_FFFE : 32'd5;
        end
        vecs.push_back(v);
        // MAX signed / MAXU, vl=4, mask 0101
        v = mk(4'd10, 4, 16'h0005, 1);
        v.a[0 +: 32] = 32'hFFFF_FFFD; v.a[32 +: 32] = 32'd9; v.a[64 +: 32] = 32'hFFFF_FFFF; v.a[96 +: 32] = 32'd2;
        for (int i = 0; i < 16; i++) v.b[i*32 +: 32] = 32'd1;
        v.expd[0 +: 32] = 32'd1; v.expd[32 +: 32] = 32'd9; v.expd[64 +: 32] = 32'd1; v.expd[96 +: 32] = 32'd2;
        vecs.push_back(v);
        v.op = 4'd12;
        v.expd[0 +: 32] = 32'hFFFF_FFFD; v.expd[64 +: 32] = 32'hFFFF_FFFF;
        vecs.push_back(v);
        // vl=0: nothing computed
        v = mk(4'd0, 0, 16'hFFFF, 0);
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'(3 * i); v.b[i*32 +: 32] = 32'd1; v.expd[i*32 +: 32] = 32'(3 * i);
        end
        vecs.push_back(v);
        // vl=20 clamps to 16: a+b = 2i everywhere
        v = mk(4'd0, 20, 16'hFFFF, 4);
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'(i); v.b[i*32 +: 32] = 32'(i); v.expd[i*32 +: 32] = 32'(2 * i);
        end
        vecs.push_back(v);
        // MUL keeps low bits: (i+1)*2^30
        v = mk(4'd2, 16, 16'hFFFF, 4);
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'(i + 1); v.b[i*32 +: 32] = 32'h4000_0000;
            v.expd[i*32 +: 32] = 32'((i + 1) % 4) << 30;
        end
        vecs.push_back(v);
        // AND vl=8
        v = mk(4'd3, 8, 16'hFFFF, 2);
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'hF0F0_F0F0; v.b[i*32 +: 32] = 32'hFF00_FF00;
            v.expd[i*32 +: 32] = (i < 8) ? 32'hF000_F000 : 32'hF0F0_F0F0;
        end
        vecs.push_back(v);
        // OR vl=4
        v.op = 4'd4; v.vl = VL_W'(4); v.mask = 16'h000F; v.lat = 1;
        for (int i = 0; i < 16; i++) v.expd[i*32 +: 32] = (i < 4) ? 32'hFFF0_FFF0 : 32'hF0F0_F0F0;
        vecs.push_back(v);
        // XOR vl=16 mask 5555: odd elements masked
        v.op = 4'd5; v.vl = VL_W'(16); v.mask = 16'h5555; v.lat = 4;
        for (int i = 0; i < 16; i++) v.expd[i*32 +: 32] = (i % 2 == 0) ? 32'h0FF0_0FF0 : 32'hF0F0_F0F0;
        vecs.push_back(v);
        // SLL with b=i+32: only low 5 bits of b count
        v = mk(4'd6, 16, 16'hFFFF, 4);
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'd1; v.b[i*32 +: 32] = 32'(i + 32); v.expd[i*32 +: 32] = 32'd1 << i;
        end
        vecs.push_back(v);
        // SRL / SRA by 4 (b=0x104)
        v = mk(4'd7, 4, 16'hFFFF, 1);
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'h8000_0000; v.b[i*32 +: 32] = 32'h104;
            v.expd[i*32 +: 32] = (i < 4) ? 32'h0800_0000 : 32'h8000_0000;
        end
        vecs.push_back(v);
        v.op = 4'd8;
        for (int i = 0; i < 4; i++) v.expd[i*32 +: 32] = 32'hF800_0000;
        vecs.push_back(v);
        // MIN signed / MINU: -5 vs 3
        v = mk(4'd9, 4, 16'hFFFF, 1);
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'hFFFF_FFFB; v.b[i*32 +: 32] = 32'd3; v.expd[i*32 +: 32] = 32'hFFFF_FFFB;
        end
        vecs.push_back(v);
        v.op = 4'd11;
        for (int i = 0; i < 4; i++) v.expd[i*32 +: 32] = 32'd3;
        vecs.push_back(v);
        // ADD wraps, vl=5 partial last beat
        v = mk(4'd0, 5, 16'hFFFF, 2);
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'hFFFF_FFFF; v.b[i*32 +: 32] = 32'd2;
            v.expd[i*32 +: 32] = (i < 5) ? 32'd1 : 32'hFFFF_FFFF;
        end
        vecs.push_back(v);
        // Illegal opcode 0xD
        v = mk(4'hD, 4, 16'hFFFF, 1);
        v.err = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'(i); v.b[i*32 +: 32] = 32'd1; v.expd[i*32 +: 32] = 32'(i);
        end
        vecs.push_back(v);
    endtask

    // Present one instruction, wait for the response (bounded), check it, retire it
    task automatic run(input vec_t v, input string tag, input bit retire);
        int cnt;
        @(negedge clk);
        check({tag, "_req_ready"}, VEC_W'(req_ready), VEC_W'(1));
        req_valid = 1'b1; req_op = v.op; req_vl = v.vl; req_mask = v.mask;
        req_src_a = v.a; req_src_b = v.b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 4'($urandom); req_vl = VL_W'($urandom); req_mask = MAX_VL'($urandom);
        req_src_a = {16{$urandom}}; req_src_b = {16{$urandom}};
        check({tag, "_busy"}, VEC_W'(busy), VEC_W'(1));
        cnt = 0;
        while (!resp_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_latency"}, VEC_W'(cnt), VEC_W'(v.lat));
        check({tag, "_data"}, resp_data, v.expd);
        check({tag, "_err"}, VEC_W'(resp_err), VEC_W'(v.err));
        check({tag, "_ready_low"}, VEC_W'(req_ready), VEC_W'(0));
        if (retire) begin
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            check({tag, "_valid_drop"}, VEC_W'(resp_valid), VEC_W'(0));
            check({tag, "_ready_back"}, VEC_W'(req_ready), VEC_W'(1));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        build();
        #2;
        check("rst_req_ready", VEC_W'(req_ready), VEC_W'(1));
        check("rst_resp_valid", VEC_W'(resp_valid), VEC_W'(0));
        check("rst_resp_err", VEC_W'(resp_err), VEC_W'(0));
        check("rst_busy", VEC_W'(busy), VEC_W'(0));
        check("rst_resp_data", resp_data, VEC_W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run(vecs[i], $sformatf("v%0d", i), 1'b1);

        // Illegal opcode 0xF, vl=8, held under backpressure for 10 cycles
        v = mk(4'hF, 8, 16'hFFFF, 2);
        v.err = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v.a[i*32 +: 32] = 32'(i + 7); v.b[i*32 +: 32] = 32'd1; v.expd[i*32 +: 32] = 32'(i + 7);
        end
        run(v, "illF", 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_valid", c), VEC_W'(resp_valid), VEC_W'(1));
            check($sformatf("hold%0d_data", c), resp_data, v.expd);
            check($sformatf("hold%0d_ready", c), VEC_W'(req_ready), VEC_W'(0));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("hold_release_valid", VEC_W'(resp_valid), VEC_W'(0));

        // Reset while EXEC is part-way through a 4-beat instruction
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd0; req_vl = VL_W'(16); req_mask = 16'hFFFF;
        req_src_a = vecs[0].a; req_src_b = vecs[0].b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("mid_busy", VEC_W'(busy), VEC_W'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", VEC_W'(resp_valid), VEC_W'(0));
        check("mid_rst_ready", VEC_W'(req_ready), VEC_W'(1));
        check("mid_rst_busy", VEC_W'(busy), VEC_W'(0));
        check("mid_rst_data", resp_data, VEC_W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run(vecs[0], "post_rst", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
